// File: rtl/ad_c2h_packer.sv
// Packs 32-bit ADC words into 128-bit AXI-Stream beats for the XDMA C2H channel.
// Optional header beat per packet when AD_C2H_HDR_EN is defined.
module ad_c2h_packer #(
  parameter int PKT_BEATS  = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic         user_clk,
  input  logic         user_resetn,
  input  logic         en,
  input  logic [31:0]  ad_data,
  input  logic         ad_valid,
  input  logic         flush,
  output logic [127:0] c2h_tdata,
  output logic [15:0]  c2h_tkeep,
  output logic         c2h_tlast,
  output logic         c2h_tvalid,
  input  logic         c2h_tready,
  output logic         ovf,
  output logic [31:0]  pkt_cnt,
  output logic [1:0]   fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
`ifdef AD_C2H_HDR_EN
  localparam logic [1:0] S_HDR   = 2'd3;
`endif
  localparam logic [15:0] LAST_BEAT = 16'(PKT_BEATS - 1);

  // Handshake: a beat transfers on the rising edge where c2h_tvalid && c2h_tready;
  // while c2h_tvalid && !c2h_tready the tdata/tkeep/tlast registers are held.

  logic [1:0]   state, state_nxt;
  logic [1:0]   pack_cnt;
  logic [95:0]  pack_data;
  logic [15:0]  beat_cnt;
  logic         en_q;
  logic         stg_valid, stg_last;
  logic [127:0] stg_data;
  logic [15:0]  stg_keep;
  logic [127:0] mem_data [FIFO_DEPTH];
  logic [15:0]  mem_keep [FIFO_DEPTH];
  logic         mem_last [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]  fifo_cnt;
`ifdef AD_C2H_HDR_EN
  logic [31:0]  hdr_seq;
`endif

  logic accept, beat_done, beat_last;
  logic out_free, pop, fifo_rd, bypass, full, fifo_wr, drop;
  logic [15:0] partial_keep;

`ifdef AD_C2H_HDR_EN
  assign accept = ad_valid && (state == S_RUN || state == S_HDR);
`else
  assign accept = ad_valid && (state == S_RUN);
`endif
  assign beat_done = accept && (pack_cnt == 2'd3);
  assign beat_last = (beat_cnt == LAST_BEAT);
  assign fsm_state = state;

  // The output register counts as one of the FIFO_DEPTH entries of capacity.
  assign out_free = !c2h_tvalid || c2h_tready;
  assign pop      = c2h_tvalid && c2h_tready;
  assign fifo_rd  = out_free && (fifo_cnt != '0);
  assign bypass   = out_free && (fifo_cnt == '0) && stg_valid;
  assign full     = (fifo_cnt + (AW+1)'(c2h_tvalid)) == (AW+1)'(FIFO_DEPTH);
  assign fifo_wr  = stg_valid && !bypass && (!full || pop);
  assign drop     = stg_valid && !bypass && full && !pop;

  always_comb begin
    partial_keep = 16'h0FFF;
    case (pack_cnt)
      2'd1:    partial_keep = 16'h000F;
      2'd2:    partial_keep = 16'h00FF;
      default: partial_keep = 16'h0FFF;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
`ifdef AD_C2H_HDR_EN
      S_IDLE:  if (en) state_nxt = S_HDR;
      S_RUN: begin
        if (flush || !en)            state_nxt = S_FLUSH;
        else if (beat_done && beat_last) state_nxt = S_HDR;
      end
      S_FLUSH: state_nxt = en ? S_HDR : S_IDLE;
      S_HDR:   state_nxt = (flush || !en) ? S_FLUSH : S_RUN;
`else
      S_IDLE:  if (en) state_nxt = S_RUN;
      S_RUN:   if (flush || !en) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = en ? S_RUN : S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (fifo_wr) begin
      mem_data[wr_ptr] <= stg_data;
      mem_keep[wr_ptr] <= stg_keep;
      mem_last[wr_ptr] <= stg_last;
    end
  end

  always_ff @(posedge user_clk) begin
    if (!user_resetn) begin
      state      <= S_IDLE;
      en_q       <= 1'b0;
      pack_cnt   <= '0;
      pack_data  <= '0;
      beat_cnt   <= '0;
      stg_valid  <= 1'b0;
      stg_data   <= '0;
      stg_keep   <= '0;
      stg_last   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      c2h_tdata  <= '0;
      c2h_tkeep  <= '0;
      c2h_tlast  <= 1'b0;
      c2h_tvalid <= 1'b0;
      ovf        <= 1'b0;
      pkt_cnt    <= '0;
`ifdef AD_C2H_HDR_EN
      hdr_seq    <= '0;
`endif
    end else begin
      state     <= state_nxt;
      en_q      <= en;
      stg_valid <= 1'b0;

      if (state == S_FLUSH) begin
        pack_cnt  <= '0;
        pack_data <= '0;
        beat_cnt  <= '0;
        if (pack_cnt != 2'd0) begin
          stg_valid <= 1'b1;
          stg_data  <= {32'h0, pack_data};
          stg_keep  <= partial_keep;
          stg_last  <= 1'b1;
        end else if (beat_cnt != 16'd0) begin
          stg_valid <= 1'b1;
          stg_data  <= '0;
          stg_keep  <= '0;
          stg_last  <= 1'b1;
        end
      end else if (accept) begin
        if (pack_cnt == 2'd3) begin
          stg_valid <= 1'b1;
          stg_data  <= {ad_data, pack_data};
          stg_keep  <= 16'hFFFF;
          stg_last  <= beat_last;
          pack_cnt  <= '0;
          pack_data <= '0;
          beat_cnt  <= beat_last ? 16'd0 : beat_cnt + 16'd1;
        end else begin
          pack_data[{pack_cnt, 5'b0} +: 32] <= ad_data;
          pack_cnt <= pack_cnt + 2'd1;
        end
      end

`ifdef AD_C2H_HDR_EN
      // At most one word can arrive in HDR, so no data beat competes for staging.
      if (state == S_HDR) begin
        stg_valid <= 1'b1;
        stg_data  <= {32'h0, 32'(PKT_BEATS), hdr_seq, 32'hADC0_0001};
        stg_keep  <= 16'hFFFF;
        stg_last  <= 1'b0;
        hdr_seq   <= hdr_seq + 32'd1;
      end
`endif

      if (drop || (state == S_FLUSH && ad_valid)) ovf <= 1'b1;
      else if (en && !en_q)                       ovf <= 1'b0;

      if (fifo_rd) begin
        c2h_tdata  <= mem_data[rd_ptr];
        c2h_tkeep  <= mem_keep[rd_ptr];
        c2h_tlast  <= mem_last[rd_ptr];
        c2h_tvalid <= 1'b1;
        rd_ptr     <= rd_ptr + 1'b1;
      end else if (bypass) begin
        c2h_tdata  <= stg_data;
        c2h_tkeep  <= stg_keep;
        c2h_tlast  <= stg_last;
        c2h_tvalid <= 1'b1;
      end else if (out_free) begin
        c2h_tvalid <= 1'b0;
      end

      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      if (pop && c2h_tlast) pkt_cnt <= pkt_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_ad_c2h_packer.sv
// Self-checking bench for ad_c2h_packer (PKT_BEATS=4, FIFO_DEPTH=16); header test
// runs when AD_C2H_HDR_EN is defined.
module tb_ad_c2h_packer;
  localparam int PKT_BEATS  = 4;
  localparam int FIFO_DEPTH = 16;

  logic         user_clk = 1'b0;
  logic         user_resetn;
  logic         en;
  logic [31:0]  ad_data;
  logic         ad_valid;
  logic         flush;
  logic [127:0] c2h_tdata;
  logic [15:0]  c2h_tkeep;
  logic         c2h_tlast;
  logic         c2h_tvalid;
  logic         c2h_tready;
  logic         ovf;
  logic [31:0]  pkt_cnt;
  logic [1:0]   fsm_state;

  logic [144:0] exp_q[$];
  logic [31:0]  m_words[$];
  int           m_beat = 0;
  int           total = 0;
  int           bad = 0;
  logic         rand_ready = 1'b0;

  ad_c2h_packer #(.PKT_BEATS(PKT_BEATS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .user_clk(user_clk), .user_resetn(user_resetn), .en(en), .ad_data(ad_data),
    .ad_valid(ad_valid), .flush(flush), .c2h_tdata(c2h_tdata), .c2h_tkeep(c2h_tkeep),
    .c2h_tlast(c2h_tlast), .c2h_tvalid(c2h_tvalid), .c2h_tready(c2h_tready),
    .ovf(ovf), .pkt_cnt(pkt_cnt), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 user_clk = ~user_clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  always @(posedge user_clk) begin
    if (rand_ready) begin
      #1 c2h_tready = 1'($urandom_range(0, 1));
    end
  end

  // scoreboard: compare each handshaken beat against the expected queue
  always @(negedge user_clk) begin
    logic [144:0] got;
    logic [144:0] want;
    if (user_resetn && c2h_tvalid && c2h_tready) begin
      got = {c2h_tlast, c2h_tkeep, c2h_tdata};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected got=%h want=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL beat got=%h want=%h", got, want);
        end
      end
    end
  end

  // reference packing model
  task automatic m_word(input logic [31:0] w);
    logic last;
    m_words.push_back(w);
    if (m_words.size() == 4) begin
      last = (m_beat == PKT_BEATS - 1);
      exp_q.push_back({last, 16'hFFFF, m_words[3], m_words[2], m_words[1], m_words[0]});
      m_words.delete();
      m_beat = last ? 0 : m_beat + 1;
    end
  endtask

  task automatic m_flush();
    logic [127:0] d;
    logic [15:0]  k;
    d = '0;
    k = '0;
    if (m_words.size() > 0) begin
      for (int i = 0; i < m_words.size(); i++) begin
        d[32*i +: 32] = m_words[i];
        k[4*i +: 4]   = 4'hF;
      end
      exp_q.push_back({1'b1, k, d});
    end else if (m_beat != 0) begin
      exp_q.push_back({1'b1, 16'h0000, 128'h0});
    end
    m_words.delete();
    m_beat = 0;
  endtask

  // driver tasks
  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit use_model);
    ad_data  = w;
    ad_valid = 1'b1;
    if (use_model) m_word(w);
    step();
    ad_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    m_flush();
    step();
    flush = 1'b0;
  endtask

  task automatic do_reset(input logic en_val);
    user_resetn = 1'b0;
    en          = en_val;
    ad_valid    = 1'b0;
    ad_data     = '0;
    flush       = 1'b0;
    rand_ready  = 1'b0;
    repeat (3) step();
    user_resetn = 1'b1;
    exp_q.delete();
    m_words.delete();
    m_beat = 0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    repeat (6) step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain left=%0d want=0", name, exp_q.size());
    end
  endtask

  task automatic check_pkt(input string name, input logic [31:0] want);
    total++;
    if (pkt_cnt !== want) begin
      bad++;
      $display("FAIL %s_pkt_cnt got=%0d want=%0d", name, pkt_cnt, want);
    end
  endtask

  // tests
  task automatic test_reset();
    user_resetn = 1'b0;
    en = 1'b0; ad_valid = 1'b0; ad_data = '0; flush = 1'b0; c2h_tready = 1'b1;
    repeat (2) step();
    total += 4;
    if (c2h_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b want=0", c2h_tvalid); end
    if ({c2h_tlast, c2h_tkeep, c2h_tdata} !== 145'h0) begin
      bad++; $display("FAIL rst_data got=%h want=0", {c2h_tlast, c2h_tkeep, c2h_tdata});
    end
    if ({ovf, pkt_cnt} !== 33'h0) begin bad++; $display("FAIL rst_ovf_cnt got=%h want=0", {ovf, pkt_cnt}); end
    if (fsm_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", fsm_state); end
    do_reset(1'b0);
  endtask

  task automatic test_full_packet();
    do_reset(1'b1);
    c2h_tready = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      send_word(32'(i), 1'b1);
      if (i == 3) begin
        total++;
        if (c2h_tvalid !== 1'b0) begin bad++; $display("FAIL lat_early got=%b want=0", c2h_tvalid); end
      end
      if (i == 4) begin
        total++;
        if (c2h_tvalid !== 1'b1 || c2h_tdata !== 128'h00000003_00000002_00000001_00000000) begin
          bad++;
          $display("FAIL lat_beat0 got=%b/%h want=1/00000003000000020000000100000000", c2h_tvalid, c2h_tdata);
        end
      end
    end
    wait_drain("full");
    check_pkt("full", 32'd1);
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL full_ovf got=%b want=0", ovf); end
  endtask

  task automatic test_partial_flush();
    do_reset(1'b1);
    c2h_tready = 1'b1;
    step();
    for (int i = 0; i < 6; i++) send_word(32'(i), 1'b1);
    pulse_flush();
    wait_drain("partial");
    check_pkt("partial", 32'd1);
  endtask

  task automatic test_null_flush();
    do_reset(1'b1);
    c2h_tready = 1'b1;
    step();
    for (int i = 0; i < 8; i++) send_word(32'(i), 1'b1);
    pulse_flush();
    wait_drain("null");
    check_pkt("null", 32'd1);
  endtask

  task automatic test_overflow();
    do_reset(1'b1);
    c2h_tready = 1'b0;
    step();
    for (int i = 0; i < 80; i++) send_word(32'(i), 1'b1);
    repeat (3) step();
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", ovf); end
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (c2h_tvalid !== 1'b1 || c2h_tlast !== 1'b0 ||
          c2h_tdata !== 128'h00000003_00000002_00000001_00000000) begin
        bad++;
        $display("FAIL ovf_hold got=%b/%b/%h want=1/0/00000003000000020000000100000000",
                 c2h_tvalid, c2h_tlast, c2h_tdata);
      end
    end
    while (exp_q.size() > FIFO_DEPTH) void'(exp_q.pop_back());
    c2h_tready = 1'b1;
    repeat (16) step();
    total++;
    if (exp_q.size() != 0 || c2h_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL ovf_rate left=%0d tvalid=%b want=0/0", exp_q.size(), c2h_tvalid);
    end
    wait_drain("ovf");
    check_pkt("ovf", 32'd4);
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", ovf); end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    c2h_tready = 1'b1;
    step();
    rand_ready = 1'b1;
    for (int i = 0; i < 32; i++) send_word($urandom, 1'b1);
    wait_drain("b2b");
    rand_ready = 1'b0;
    @(posedge user_clk);
    #2;
    c2h_tready = 1'b1;
    step();
    check_pkt("b2b", 32'd2);
  endtask

  task automatic test_en_drop();
    do_reset(1'b0);
    c2h_tready = 1'b1;
    for (int i = 0; i < 4; i++) send_word(32'hA0 + 32'(i), 1'b0);
    repeat (4) step();
    total++;
    if (fsm_state !== 2'd0) begin bad++; $display("FAIL idle_state got=%0d want=0", fsm_state); end
    en = 1'b1;
    step();
    send_word(32'h1111_0000, 1'b1);
    send_word(32'h2222_0000, 1'b1);
    pulse_flush();
    send_word(32'hDEAD_BEEF, 1'b0);
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL flush_word_ovf got=%b want=1", ovf); end
    wait_drain("en_drop");
    en = 1'b0;
    repeat (3) step();
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_hold_en0 got=%b want=1", ovf); end
    en = 1'b1;
    repeat (2) step();
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", ovf); end
    check_pkt("en_drop", 32'd1);
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    c2h_tready = 1'b1;
    step();
    for (int i = 0; i < 10; i++) send_word(32'(i), 1'b1);
    repeat (4) step();
    user_resetn = 1'b0;
    step();
    user_resetn = 1'b1;
    exp_q.delete();
    m_words.delete();
    m_beat = 0;
    total++;
    if ({c2h_tvalid, c2h_tlast, c2h_tkeep, c2h_tdata, ovf, pkt_cnt} !== 179'h0) begin
      bad++;
      $display("FAIL mid_rst_outputs got=%b/%b/%h/%h want=0", c2h_tvalid, c2h_tlast, c2h_tkeep, c2h_tdata);
    end
    step();
    total++;
    if (c2h_tvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_next got=%b want=0", c2h_tvalid); end
    repeat (20) step();
    check_pkt("mid_rst", 32'd0);
  endtask

`ifdef AD_C2H_HDR_EN
  task automatic m_hdr(input logic [31:0] seq);
    exp_q.push_back({1'b0, 16'hFFFF, 32'h0, 32'(PKT_BEATS), seq, 32'hADC0_0001});
  endtask

  task automatic test_hdr();
    do_reset(1'b0);
    c2h_tready = 1'b1;
    en = 1'b1;
    m_hdr(32'd0);
    step();
    for (int i = 0; i < 16; i++) send_word(32'(i), 1'b1);
    m_hdr(32'd1);
    for (int i = 16; i < 32; i++) send_word(32'(i), 1'b1);
    m_hdr(32'd2);
    wait_drain("hdr");
    check_pkt("hdr", 32'd2);
  endtask
`endif

  initial begin
    c2h_tready = 1'b1;
    test_reset();
`ifdef AD_C2H_HDR_EN
    test_hdr();
`else
    test_full_packet();
    test_partial_flush();
    test_null_flush();
    test_overflow();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
